// File: rtl/irda_cmd_ctrl_pkg.sv
// Shared types for the IR command controller: register map, CTRL/STATUS bits, NEC frame and FIFO entry layouts.
// Pure declarations; no timing or flow control here.
package irda_cmd_ctrl_pkg;

    typedef enum logic [1:0] {
        REG_STATUS = 2'd0,
        REG_DATA   = 2'd1,
        REG_CTRL   = 2'd2,
        REG_FILTER = 2'd3
    } reg_sel_e;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_FILT   = 2;
    localparam int CTRL_REP    = 3;
    localparam int CTRL_FLUSH  = 31;

    localparam int STAT_NE   = 0;
    localparam int STAT_FULL = 1;
    localparam int STAT_OVF  = 2;
    localparam int STAT_CNT  = 4;

    localparam int ENTRY_W = 17;

    typedef struct packed {
        logic rep;
        logic filt;
        logic irq_en;
        logic en;
    } ctrl_t;

    typedef struct packed {
        logic [7:0] cmd_n;
        logic [7:0] cmd;
        logic [7:0] addr_n;
        logic [7:0] addr;
    } nec_frame_t;

    typedef struct packed {
        logic       rpt;
        logic [7:0] cmd;
        logic [7:0] addr;
    } entry_t;

    function automatic logic frame_ok(nec_frame_t f);
        return f.cmd_n == ~f.cmd;
    endfunction

endpackage

// File: rtl/irda_cmd_ctrl_if.sv
// Frame-receiver and MMIO register bus bundle between the core and the IR command controller.
// Master drives strobes and write data; slave returns registered read data and the level interrupt.
interface irda_cmd_ctrl_if;
    logic        iDATA_READY;
    logic [31:0] iDATA;
    logic [1:0]  iADDR;
    logic        iRD;
    logic        iWR;
    logic [31:0] iWDATA;
    logic [31:0] oRDATA;
    logic        oIRQ;

    modport master (
        output iDATA_READY, iDATA, iADDR, iRD, iWR, iWDATA,
        input  oRDATA, oIRQ
    );

    modport slave (
        input  iDATA_READY, iDATA, iADDR, iRD, iWR, iWDATA,
        output oRDATA, oIRQ
    );
endinterface

// File: rtl/irda_cmd_ctrl_fifo.sv
// Command entry FIFO with push/pop/flush; writes land at the clock edge, head is read combinationally.
// Push while full is dropped and flagged unless a pop in the same cycle frees the slot; flush beats push.
module irda_cmd_ctrl_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 17
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [W-1:0]               push_dat,
    input  logic                       pop,
    input  logic                       flush,
    output logic [W-1:0]               head_dat,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       ovf_evt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full     = (cnt_q == CW'(DEPTH));
    assign empty    = (cnt_q == '0);
    assign count    = cnt_q;
    assign head_dat = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop & ~empty;
        // A pop in the same cycle frees the head slot before the push lands.
        do_push  = push & (~full | do_pop);
        ovf_evt  = push & ~do_push & ~flush;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d = wr_ptr_q + AW'(do_push);
            rd_ptr_d = rd_ptr_q + AW'(do_pop);
            cnt_d    = cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: rtl/irda_cmd_ctrl.sv
// NEC IR command controller: validates frames, tags key-hold repeats, queues entries and exposes MMIO regs + IRQ.
// Strobe edge to entry in STATUS is 2 cycles; reads return the cycle after iRD; a full queue drops and sets ovf.
module irda_cmd_ctrl
    import irda_cmd_ctrl_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int HOLD_WINDOW = 6000000
) (
    input logic            iCLK,
    input logic            iRST_n,
    irda_cmd_ctrl_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int TW = $clog2(HOLD_WINDOW + 1);
    localparam logic [TW-1:0] HOLD_MAX = TW'(HOLD_WINDOW);

    logic          rdy_q, rdy_d;
    logic          frm_vld_q, frm_vld_d;
    nec_frame_t    frm_q, frm_d, last_q, last_d;
    logic [TW-1:0] timer_q, timer_d;
    ctrl_t         ctrl_q, ctrl_d;
    logic [7:0]    filter_q, filter_d;
    logic          ovf_q, ovf_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          irq_q, irq_d;

    reg_sel_e      sel;
    logic          accept, is_rep, push, pop, flush, wr_en, rd_en;
    logic          full, empty, ovf_evt;
    logic [CW-1:0] count;
    entry_t        push_dat, head_dat;
    logic          unused_wdata;

    assign unused_wdata = &{1'b0, bus.iWDATA[30:8]};

    irda_cmd_ctrl_fifo #(.DEPTH(DEPTH), .W(ENTRY_W)) u_fifo (
        .clk      (iCLK),
        .rst_n    (iRST_n),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .flush    (flush),
        .head_dat (head_dat),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .ovf_evt  (ovf_evt)
    );

    always_comb begin
        // Frame is captured on the strobe's rising edge and judged one cycle later.
        rdy_d     = bus.iDATA_READY;
        frm_vld_d = bus.iDATA_READY & ~rdy_q;
        frm_d     = frm_vld_d ? nec_frame_t'(bus.iDATA) : frm_q;

        accept   = frm_vld_q & ctrl_q.en & frame_ok(frm_q)
                 & (~ctrl_q.filt | (frm_q.addr == filter_q));
        is_rep   = (frm_q == last_q) && (timer_q < HOLD_MAX);
        push     = accept & (~is_rep | ctrl_q.rep);
        push_dat = {is_rep, frm_q.cmd, frm_q.addr};
        last_d   = accept ? frm_q : last_q;
        timer_d  = accept ? '0 : ((timer_q < HOLD_MAX) ? timer_q + TW'(1) : timer_q);

        sel   = reg_sel_e'(bus.iADDR);
        wr_en = bus.iWR;
        rd_en = bus.iRD & ~bus.iWR;
        pop   = rd_en && (sel == REG_DATA);
        flush = wr_en && (sel == REG_CTRL) && bus.iWDATA[CTRL_FLUSH];

        ctrl_d   = ctrl_q;
        filter_d = filter_q;
        if (wr_en && sel == REG_CTRL)   ctrl_d   = ctrl_t'(bus.iWDATA[3:0]);
        if (wr_en && sel == REG_FILTER) filter_d = bus.iWDATA[7:0];

        ovf_d = ovf_q;
        if (wr_en && sel == REG_STATUS && bus.iWDATA[STAT_OVF]) ovf_d = 1'b0;
        if (ovf_evt) ovf_d = 1'b1;

        rdata_d = '0;
        if (rd_en) begin
            case (sel)
                REG_STATUS: begin
                    rdata_d[STAT_NE]         = ~empty;
                    rdata_d[STAT_FULL]       = full;
                    rdata_d[STAT_OVF]        = ovf_q;
                    rdata_d[STAT_CNT +: CW]  = count;
                end
                REG_DATA:   if (!empty) rdata_d[ENTRY_W-1:0] = head_dat;
                REG_CTRL:   rdata_d[3:0] = ctrl_q;
                REG_FILTER: rdata_d[7:0] = filter_q;
                default:    rdata_d = '0;
            endcase
        end

        irq_d = ctrl_q.irq_en & (~empty | ovf_q);
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_n) begin
            rdy_q     <= 1'b0;
            frm_vld_q <= 1'b0;
            frm_q     <= '0;
            last_q    <= '0;
            timer_q   <= '0;
            ctrl_q    <= '0;
            filter_q  <= '0;
            ovf_q     <= 1'b0;
            rdata_q   <= '0;
            irq_q     <= 1'b0;
        end else begin
            rdy_q     <= rdy_d;
            frm_vld_q <= frm_vld_d;
            frm_q     <= frm_d;
            last_q    <= last_d;
            timer_q   <= timer_d;
            ctrl_q    <= ctrl_d;
            filter_q  <= filter_d;
            ovf_q     <= ovf_d;
            rdata_q   <= rdata_d;
            irq_q     <= irq_d;
        end
    end

    assign bus.oRDATA = rdata_q;
    assign bus.oIRQ   = irq_q;
endmodule
